enet_ddr_bram_responder: RTL and testbench

- Responder end of the Ethernet-to-DDR request interface: services the write/read requests issued by the Ethernet DDR controller and returns acks and read data.
- Backs requests with an on-chip 256-bit-wide block RAM. Used for DDR-less loopback bring-up and as the memory model in Ethernet subsystem benches.
- Single clock domain, same clock as the Ethernet DDR controller. One outstanding request at a time.

---
 rtl/enet_ddr_bram_responder_if.sv | 27 ++
 rtl/enet_ddr_bram_responder.sv | 121 ++++++++++++
 tb/tb_enet_ddr_bram_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enet_ddr_bram_responder_if.sv
// Ethernet-to-DDR request bus between the controller (master) and a memory responder (slave).
// Status outputs (error flag, transfer counters) ride on the same bundle.
interface enet_ddr_bram_responder_if;
  logic         ddr_wr_req;
  logic         ddr_rd_req;
  logic [255:0] ddr_wr_data;
  logic [31:0]  ddr_wr_be;
  logic [31:0]  ddr_wr_addr;
  logic [31:0]  ddr_rd_addr;
  logic [255:0] ddr_rd_data;
  logic         ddr_wr_ack;
  logic         ddr_rd_ack;
  logic         ddr_rd_data_valid;
  logic         addr_err;
  logic [31:0]  wr_cnt;
  logic [31:0]  rd_cnt;

  modport master (
    output ddr_wr_req, ddr_rd_req, ddr_wr_data, ddr_wr_be, ddr_wr_addr, ddr_rd_addr,
    input  ddr_rd_data, ddr_wr_ack, ddr_rd_ack, ddr_rd_data_valid, addr_err, wr_cnt, rd_cnt
  );

  modport slave (
    input  ddr_wr_req, ddr_rd_req, ddr_wr_data, ddr_wr_be, ddr_wr_addr, ddr_rd_addr,
    output ddr_rd_data, ddr_wr_ack, ddr_rd_ack, ddr_rd_data_valid, addr_err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/enet_ddr_bram_responder.sv
// Block-RAM backed responder for the Ethernet DDR request bus: one outstanding
// request, byte-enabled writes, fixed-latency reads, round-robin on write/read ties.
module enet_ddr_bram_responder #(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  enet_ddr_bram_responder_if.slave     ddr
);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_ACK, RD_WAIT} state_t;

  localparam int         WORDS  = 1 << MEM_AW;
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  logic [255:0]      mem [WORDS];
  state_t            state;
  logic              prio_rd;
  logic [3:0]        lat_cnt;
  logic              wr_grant, rd_grant;
  logic              wr_oor, rd_oor;
  logic [MEM_AW-1:0] wr_idx, rd_idx;
  logic [255:0]      rd_word_p1;
  logic              rd_oor_p1;

  function automatic logic addr_oor(input logic [31:0] a);
    return |(a >> (MEM_AW + 5));
  endfunction

  // Tie-break pointer only moves when both requests actually compete.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (state == IDLE) begin
      if (ddr.ddr_wr_req && ddr.ddr_rd_req) begin
        wr_grant = !prio_rd;
        rd_grant = prio_rd;
      end else begin
        wr_grant = ddr.ddr_wr_req;
        rd_grant = ddr.ddr_rd_req;
      end
    end
    wr_oor = addr_oor(ddr.ddr_wr_addr);
    rd_oor = addr_oor(ddr.ddr_rd_addr);
    wr_idx = ddr.ddr_wr_addr[MEM_AW+4:5];
    rd_idx = ddr.ddr_rd_addr[MEM_AW+4:5];
  end

  // Stage p1: RAM commit / sync read on the edge that leaves IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_grant && !wr_oor) begin
      for (int i = 0; i < 32; i++) begin
        if (ddr.ddr_wr_be[i]) mem[wr_idx][8*i +: 8] <= ddr.ddr_wr_data[8*i +: 8];
      end
    end
    if (i_rst_n && rd_grant) begin
      rd_word_p1 <= mem[rd_idx];
      rd_oor_p1  <= rd_oor;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      prio_rd               <= 1'b0;
      lat_cnt               <= '0;
      ddr.ddr_wr_ack        <= 1'b0;
      ddr.ddr_rd_ack        <= 1'b0;
      ddr.ddr_rd_data_valid <= 1'b0;
      ddr.ddr_rd_data       <= '0;
      ddr.addr_err          <= 1'b0;
      ddr.wr_cnt            <= '0;
      ddr.rd_cnt            <= '0;
    end else begin
      ddr.ddr_wr_ack <= 1'b0;
      ddr.ddr_rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_grant) begin
            state          <= WR_ACK;
            ddr.ddr_wr_ack <= 1'b1;
            ddr.wr_cnt     <= ddr.wr_cnt + 32'd1;
            if (wr_oor) ddr.addr_err <= 1'b1;
            if (ddr.ddr_rd_req) prio_rd <= 1'b1;
          end else if (rd_grant) begin
            state          <= RD_ACK;
            ddr.ddr_rd_ack <= 1'b1;
            ddr.rd_cnt     <= ddr.rd_cnt + 32'd1;
            if (rd_oor) ddr.addr_err <= 1'b1;
            if (ddr.ddr_wr_req) prio_rd <= 1'b0;
          end
        end
        WR_ACK: state <= IDLE;
        RD_ACK: begin
          state   <= RD_WAIT;
          lat_cnt <= LAT_M1;
          if (RD_LAT == 1) begin
            ddr.ddr_rd_data_valid <= 1'b1;
            ddr.ddr_rd_data       <= rd_oor_p1 ? '0 : rd_word_p1;
          end
        end
        RD_WAIT: begin
          if (ddr.ddr_rd_data_valid) begin
            ddr.ddr_rd_data_valid <= 1'b0;
            state                 <= IDLE;
          end else begin
            if (lat_cnt == 4'd1) begin
              ddr.ddr_rd_data_valid <= 1'b1;
              ddr.ddr_rd_data       <= rd_oor_p1 ? '0 : rd_word_p1;
            end
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enet_ddr_bram_responder.sv
// Directed bench for enet_ddr_bram_responder (MEM_AW=10, RD_LAT=2).
module tb_enet_ddr_bram_responder;
  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [255:0] PAT_A = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PAT_B = {8{32'hCAFE_F00D}};

  enet_ddr_bram_responder_if bus();

  enet_ddr_bram_responder #(.MEM_AW(10), .RD_LAT(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ddr     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [255:0] d, input logic [31:0] be,
                        output int lat);
    bus.ddr_wr_addr = a;
    bus.ddr_wr_data = d;
    bus.ddr_wr_be   = be;
    bus.ddr_wr_req  = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.ddr_wr_ack) begin
        lat = c;
        break;
      end
    end
    bus.ddr_wr_req = 1'b0;
    step();
  endtask

  task automatic rd_txn(input logic [31:0] a, output int ack_lat, output int vld_lat,
                        output logic [255:0] d, output logic vld_after);
    bus.ddr_rd_addr = a;
    bus.ddr_rd_req  = 1'b1;
    ack_lat = -1;
    vld_lat = -1;
    d = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.ddr_rd_ack && ack_lat < 0) begin
        ack_lat = c;
        bus.ddr_rd_req = 1'b0;
      end
      if (bus.ddr_rd_data_valid) begin
        vld_lat = c;
        d = bus.ddr_rd_data;
        break;
      end
    end
    bus.ddr_rd_req = 1'b0;
    step();
    vld_after = bus.ddr_rd_data_valid;
  endtask

  // Raises both requests together; returns which was acked first/second (1=write, 2=read).
  task automatic run_pair(output int first, output int second);
    int  k;
    logic seen_vld;
    k = 0; first = 0; second = 0; seen_vld = 1'b0;
    bus.ddr_wr_addr = 32'h300;
    bus.ddr_wr_data = PAT_B;
    bus.ddr_wr_be   = '1;
    bus.ddr_rd_addr = 32'h40;
    bus.ddr_wr_req  = 1'b1;
    bus.ddr_rd_req  = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.ddr_wr_ack) begin
        if (k == 0) first = 1; else second = 1;
        k++;
        bus.ddr_wr_req = 1'b0;
      end
      if (bus.ddr_rd_ack) begin
        if (k == 0) first = 2; else second = 2;
        k++;
        bus.ddr_rd_req = 1'b0;
      end
      if (bus.ddr_rd_data_valid) seen_vld = 1'b1;
      if (k >= 2 && seen_vld) begin
        step();
        break;
      end
    end
    bus.ddr_wr_req = 1'b0;
    bus.ddr_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++;
    if ({bus.ddr_wr_ack, bus.ddr_rd_ack, bus.ddr_rd_data_valid, bus.addr_err} !== 4'b0000)
      $display("FAIL reset_flags got %b required 0000",
               {bus.ddr_wr_ack, bus.ddr_rd_ack, bus.ddr_rd_data_valid, bus.addr_err});
    else n_pass++;
    n_total++;
    if (bus.wr_cnt !== 32'd0 || bus.rd_cnt !== 32'd0)
      $display("FAIL reset_cnt got wr=%0d rd=%0d required 0/0", bus.wr_cnt, bus.rd_cnt);
    else n_pass++;
    n_total++;
    if (bus.ddr_rd_data !== 256'd0) $display("FAIL reset_data got %h required 0", bus.ddr_rd_data);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat, alat, vlat;
    logic [255:0] d;
    logic va;
    wr_txn(32'h40, PAT_A, 32'hFFFF_FFFF, lat);
    n_total++;
    if (lat !== 1) $display("FAIL basic_wr_ack_lat got %0d required 1", lat); else n_pass++;
    n_total++;
    if (bus.wr_cnt !== 32'd1) $display("FAIL basic_wr_cnt got %0d required 1", bus.wr_cnt); else n_pass++;
    rd_txn(32'h40, alat, vlat, d, va);
    n_total++;
    if (alat !== 1) $display("FAIL basic_rd_ack_lat got %0d required 1", alat); else n_pass++;
    n_total++;
    if (vlat !== 3) $display("FAIL basic_rd_vld_lat got %0d required 3", vlat); else n_pass++;
    n_total++;
    if (d !== PAT_A) $display("FAIL basic_rd_data got %h required %h", d, PAT_A); else n_pass++;
    n_total++;
    if (va !== 1'b0) $display("FAIL basic_vld_width got %b required 0 after strobe", va); else n_pass++;
    n_total++;
    if (bus.rd_cnt !== 32'd1) $display("FAIL basic_rd_cnt got %0d required 1", bus.rd_cnt); else n_pass++;
  endtask

  task automatic test_partial();
    int lat, alat, vlat;
    logic [255:0] d;
    logic va;
    logic [255:0] exp;
    exp = {{28{8'hFF}}, 32'h0000_0000};
    wr_txn(32'h80, {32{8'hFF}}, 32'hFFFF_FFFF, lat);
    wr_txn(32'h80, 256'd0, 32'h0000_000F, lat);
    n_total++;
    if (lat !== 1) $display("FAIL partial_wr_ack_lat got %0d required 1", lat); else n_pass++;
    rd_txn(32'h80, alat, vlat, d, va);
    n_total++;
    if (d !== exp) $display("FAIL partial_rd_data got %h required %h", d, exp); else n_pass++;
    n_total++;
    if (bus.wr_cnt !== 32'd3) $display("FAIL partial_wr_cnt got %0d required 3", bus.wr_cnt); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int f, s;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_pair(f, s);
    n_total++;
    if (f !== 1 || s !== 2) $display("FAIL tie_pair1 got order %0d,%0d required 1,2", f, s); else n_pass++;
    run_pair(f, s);
    n_total++;
    if (f !== 2 || s !== 1) $display("FAIL tie_pair2 got order %0d,%0d required 2,1", f, s); else n_pass++;
    n_total++;
    if (bus.wr_cnt !== 32'd2 || bus.rd_cnt !== 32'd2)
      $display("FAIL tie_cnt got wr=%0d rd=%0d required 2/2", bus.wr_cnt, bus.rd_cnt);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    int lat, alat, vlat;
    logic [255:0] d;
    logic va;
    wr_txn(32'h0, PAT_B, 32'hFFFF_FFFF, lat);
    n_total++;
    if (bus.addr_err !== 1'b0) $display("FAIL oor_err_clean got %b required 0", bus.addr_err); else n_pass++;
    wr_txn(32'h0000_8000, PAT_A, 32'hFFFF_FFFF, lat);
    n_total++;
    if (lat !== 1) $display("FAIL oor_wr_ack_lat got %0d required 1", lat); else n_pass++;
    n_total++;
    if (bus.addr_err !== 1'b1) $display("FAIL oor_err_set got %b required 1", bus.addr_err); else n_pass++;
    rd_txn(32'h0000_8000, alat, vlat, d, va);
    n_total++;
    if (alat !== 1 || vlat !== 3)
      $display("FAIL oor_rd_timing got ack=%0d vld=%0d required 1/3", alat, vlat);
    else n_pass++;
    n_total++;
    if (d !== 256'd0) $display("FAIL oor_rd_data got %h required 0", d); else n_pass++;
    rd_txn(32'h0, alat, vlat, d, va);
    n_total++;
    if (d !== PAT_B) $display("FAIL oor_word0_intact got %h required %h", d, PAT_B); else n_pass++;
    n_total++;
    if (bus.addr_err !== 1'b1) $display("FAIL oor_err_sticky got %b required 1", bus.addr_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0]  ack_mask;
    logic [31:0] cnt0;
    int          n_ack;
    logic        prev_ack;
    int alat, vlat;
    logic [255:0] d;
    logic va;
    ack_mask = '0;
    n_ack = 0;
    prev_ack = 1'b0;
    cnt0 = bus.wr_cnt;
    bus.ddr_wr_addr = 32'h100;
    bus.ddr_wr_data = {8{32'h1111_1111}};
    bus.ddr_wr_be   = '1;
    bus.ddr_wr_req  = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (prev_ack && n_ack < 4) begin
        bus.ddr_wr_addr = 32'h100 + 32'(n_ack * 32);
        bus.ddr_wr_data = {8{32'h1111_1111 * 32'(n_ack + 1)}};
      end
      prev_ack = bus.ddr_wr_ack;
      if (bus.ddr_wr_ack) begin
        ack_mask[c] = 1'b1;
        n_ack++;
        if (n_ack == 4) bus.ddr_wr_req = 1'b0;
      end
    end
    bus.ddr_wr_req = 1'b0;
    n_total++;
    if (ack_mask !== 10'h0AA) $display("FAIL b2b_ack_cycles got %b required 0010101010", ack_mask); else n_pass++;
    n_total++;
    if (bus.wr_cnt - cnt0 !== 32'd4) $display("FAIL b2b_wr_cnt got %0d required 4", bus.wr_cnt - cnt0); else n_pass++;
    rd_txn(32'h160, alat, vlat, d, va);
    n_total++;
    if (d !== {8{32'h4444_4444}}) $display("FAIL b2b_last_word got %h required %h", d, {8{32'h4444_4444}});
    else n_pass++;
    rd_txn(32'h100, alat, vlat, d, va);
    n_total++;
    if (d !== {8{32'h1111_1111}}) $display("FAIL b2b_first_word got %h required %h", d, {8{32'h1111_1111}});
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int   n_vld;
    int   alat, vlat;
    logic [255:0] d;
    logic va;
    bus.ddr_rd_addr = 32'h40;
    bus.ddr_rd_req  = 1'b1;
    step();
    n_total++;
    if (bus.ddr_rd_ack !== 1'b1) $display("FAIL mid_rd_ack got %b required 1", bus.ddr_rd_ack); else n_pass++;
    bus.ddr_rd_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_total++;
    if ({bus.ddr_wr_ack, bus.ddr_rd_ack, bus.ddr_rd_data_valid, bus.addr_err} !== 4'b0000 ||
        bus.wr_cnt !== 32'd0 || bus.rd_cnt !== 32'd0 || bus.ddr_rd_data !== 256'd0)
      $display("FAIL mid_reset_outputs got flags=%b wr=%0d rd=%0d required all 0",
               {bus.ddr_wr_ack, bus.ddr_rd_ack, bus.ddr_rd_data_valid, bus.addr_err},
               bus.wr_cnt, bus.rd_cnt);
    else n_pass++;
    rst_n = 1'b1;
    n_vld = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.ddr_rd_data_valid) n_vld++;
    end
    n_total++;
    if (n_vld !== 0) $display("FAIL mid_no_valid got %0d strobes required 0", n_vld); else n_pass++;
    rd_txn(32'h40, alat, vlat, d, va);
    n_total++;
    if (d !== PAT_A) $display("FAIL mid_ram_intact got %h required %h", d, PAT_A); else n_pass++;
    n_total++;
    if (bus.rd_cnt !== 32'd1) $display("FAIL mid_rd_cnt got %0d required 1", bus.rd_cnt); else n_pass++;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.ddr_wr_req  = 1'b0;
    bus.ddr_rd_req  = 1'b0;
    bus.ddr_wr_data = '0;
    bus.ddr_wr_be   = '0;
    bus.ddr_wr_addr = '0;
    bus.ddr_rd_addr = '0;
    test_reset();
    test_basic();
    test_partial();
    test_simultaneous();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
